// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// the default stability window and small state-decoding helpers.
package debounce_pkg;

    // 5 ms at 100 MHz
    localparam int STABLE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Output level presented while in a given state.
    function automatic logic level_of(input state_t s);
        return (s == HIGH) || (s == WAIT_LOW);
    endfunction

    // True while a level change is being qualified.
    function automatic logic is_wait(input state_t s);
        return (s == WAIT_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous external inputs.
// Ports: clk, rst (async, active-high), d (async input), q (synchronized).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button/switch level into a clean level synchronous to clk.
// Ports: clk, rst (async, active-high), raw_in (async raw level),
// db_out (debounced level, registered from the FSM).
// Optional macro DEBOUNCE_BUSY_EN adds output busy (high while qualifying).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out
`ifdef DEBOUNCE_BUSY_EN
    ,
    output logic busy
`endif
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sig_s;
    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sig_s)
    );

    // The counter is cleared on every state change, so the compare against
    // CNT_LAST alone keeps it from wrapping.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOW: begin
                if (sig_s) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sig_s) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            HIGH: begin
                if (!sig_s) begin
                    state_nx = WAIT_LOW;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOW: begin
                if (sig_s) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nx = LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOW;
            cnt    <= '0;
            db_out <= 1'b0;
`ifdef DEBOUNCE_BUSY_EN
            busy   <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            db_out <= level_of(state_nx);
`ifdef DEBOUNCE_BUSY_EN
            busy   <= is_wait(state_nx);
`endif
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with STABLE_CYCLES=4.
// Build with DEBOUNCE_BUSY_EN defined to also check the busy output.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b1;
    logic db_out;
`ifdef DEBOUNCE_BUSY_EN
    logic busy;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .db_out (db_out)
`ifdef DEBOUNCE_BUSY_EN
        ,
        .busy   (busy)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_busy(input string tag, input logic exp);
`ifdef DEBOUNCE_BUSY_EN
        check(tag, 32'(busy), 32'(exp));
`else
        check(tag, 32'(dut.state == 2'd1 || dut.state == 2'd3), 32'(exp));
`endif
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_low(input string tag);
        raw_in = 1'b0;
        repeat (8) tick();
        check(tag, 32'(db_out), 32'd0);
        check({tag, " st"}, 32'(dut.state), 32'd0);
    endtask

    logic [5:0] bounce;

    initial begin
        // Reset with raw_in high, then release.
        #1;
        check("rst db", 32'(db_out), 32'd0);
        tick();
        tick();
        check("rst db2", 32'(db_out), 32'd0);
        check_busy("rst busy", 1'b0);
        check("rst cnt", 32'(dut.cnt), 32'd0);
        rst = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            check($sformatf("rel db k=%0d", k),
                  32'(db_out), 32'(k >= 6));
            check_busy($sformatf("rel busy k=%0d", k), k >= 2 && k <= 5);
        end

        // Steady 0->1.
        settle_low("t2 pre");
        raw_in = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            check($sformatf("rise db k=%0d", k),
                  32'(db_out), 32'(k >= 6));
            check_busy($sformatf("rise busy k=%0d", k), k >= 2 && k <= 5);
        end

        // 4-clock pulse is rejected.
        settle_low("t3 pre");
        for (int k = 0; k <= 12; k++) begin
            raw_in = (k < 4);
            tick();
            check($sformatf("p4 db k=%0d", k), 32'(db_out), 32'd0);
        end
        check("p4 state", 32'(dut.state), 32'd0);
        check_busy("p4 busy", 1'b0);

        // 5-clock pulse is accepted, then released.
        settle_low("t4 pre");
        for (int k = 0; k <= 13; k++) begin
            raw_in = (k < 5);
            tick();
            check($sformatf("p5 db k=%0d", k),
                  32'(db_out), 32'(k >= 6 && k <= 10));
        end

        // Bounce train 1,0,1,1,0,1 then steady 1.
        settle_low("t5 pre");
        bounce = 6'b101101;
        for (int k = 0; k <= 13; k++) begin
            raw_in = (k < 6) ? bounce[5-k] : 1'b1;
            tick();
            check($sformatf("bnc db k=%0d", k),
                  32'(db_out), 32'(k >= 11));
        end

        // Reset in WAIT_LOW with cnt=2.
        raw_in = 1'b0;
        repeat (5) tick();
        check("wl db", 32'(db_out), 32'd1);
        check("wl state", 32'(dut.state), 32'd3);
        check("wl cnt", 32'(dut.cnt), 32'd2);
        check_busy("wl busy", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst db", 32'(db_out), 32'd0);
        check("arst cnt", 32'(dut.cnt), 32'd0);
        check("arst state", 32'(dut.state), 32'd0);
        check_busy("arst busy", 1'b0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("post db", 32'(db_out), 32'd0);
        check_busy("post busy", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
